// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready flow control, a one-entry skid
// buffer and synchronous flush. Control enables leave the block gated by valid.
module exe_mem_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] val_rm,
   output logic [DEST_W-1:0] dest,
   output logic [1:0]        occupancy
);

   localparam int ENT_W = 3 + 2 * DATA_W + DEST_W;

   logic             main_valid;
   logic             skid_valid;
   logic [ENT_W-1:0] main_q;
   logic [ENT_W-1:0] skid_q;
   logic [ENT_W-1:0] in_ent;
   logic             accept;
   logic             consume;
   logic             main_wb;
   logic             main_mr;
   logic             main_mw;

   assign in_ent  = {wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in};

   // in_ready depends only on registered state, so out_ready never reaches it combinationally.
   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready;
   assign consume  = main_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || consume) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= accept;
            if (accept) skid_q <= in_ent;
         end else begin
            main_valid <= accept;
            if (accept) main_q <= in_ent;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_q     <= in_ent;
      end
   end

   assign {main_wb, main_mr, main_mw, alu_result, val_rm, dest} = main_q;

   assign out_valid = main_valid;
   assign wb_en     = main_valid & main_wb;
   assign mem_r_en  = main_valid & main_mr;
   assign mem_w_en  = main_valid & main_mw;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg (DATA_W=64, DEST_W=5): constant vector table,
// hand sequences for flush/gating/reset, and random traffic against a queue model.
module tb_exe_mem_pipe_reg;

  localparam int DW = 64;
  localparam int TW = 5;
  localparam int EW = 3 + 2 * DW + TW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [DW-1:0] alu_result_in, val_rm_in;
  logic [TW-1:0] dest_in;
  logic          out_valid;
  logic          out_ready;
  logic          wb_en, mem_r_en, mem_w_en;
  logic [DW-1:0] alu_result, val_rm;
  logic [TW-1:0] dest;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  // entries held by the block, oldest first; the front one is what the outputs show
  logic [EW-1:0] exp_q[$];

  exe_mem_pipe_reg #(.DATA_W(DW), .DEST_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .val_rm(val_rm), .dest(dest),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic          m_wb, m_mr, m_mw, m_ov;
    logic [DW-1:0] m_alu, m_vrm;
    logic [TW-1:0] m_dest;
    m_ov = (exp_q.size() > 0);
    {m_wb, m_mr, m_mw, m_alu, m_vrm, m_dest} = m_ov ? exp_q[0] : '0;
    chk("model in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
    chk("model out_valid", DW'(out_valid), DW'(m_ov));
    chk("model occupancy", DW'(occupancy), DW'(exp_q.size()));
    chk("model wb_en", DW'(wb_en), DW'(m_ov & m_wb));
    chk("model mem_r_en", DW'(mem_r_en), DW'(m_ov & m_mr));
    chk("model mem_w_en", DW'(mem_w_en), DW'(m_ov & m_mw));
    if (m_ov) begin
      chk("model alu_result", alu_result, m_alu);
      chk("model val_rm", val_rm, m_vrm);
      chk("model dest", DW'(dest), DW'(m_dest));
    end
  endtask

  // driver: called just after a rising edge; drives inputs, then checks at the falling edge
  task automatic apply(input logic iv, input logic wb, input logic mr, input logic mw,
                       input logic [DW-1:0] alu, input logic [DW-1:0] vrm,
                       input logic [TW-1:0] dst, input logic ordy, input logic fl);
    in_valid = iv; wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
    alu_result_in = alu; val_rm_in = vrm; dest_in = dst;
    out_ready = ordy; flush = fl;
    @(negedge clk);
    model_check();
  endtask

  // advance one clock edge and move the model by the transfer rules
  task automatic tick();
    bit acc, cons;
    acc  = in_valid && (exp_q.size() < 2);
    cons = (exp_q.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in});
    end
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] alu;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_alu;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // back-pressure: 0xA, 0xB, 0xC offered while out_ready is low for 3 cycles
    vecs[0] = '{1'b1, 64'hA, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1};
    vecs[1] = '{1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 64'hC, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0};
    vecs[3] = '{1'b1, 64'hC, 1'b1, 1'b1, 64'hA, 2'd2, 1'b0};
    vecs[4] = '{1'b1, 64'hC, 1'b1, 1'b1, 64'hB, 2'd1, 1'b1};
    vecs[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hC, 2'd1, 1'b1};
    vecs[6] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_result_in = '0; val_rm_in = '0; dest_in = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", DW'(out_valid), 64'd0);
    chk("reset alu_result", alu_result, 64'd0);
    chk("reset dest", DW'(dest), 64'd0);
    chk("reset in_ready", DW'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // streaming: each entry appears exactly one cycle later
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) apply(1'b1, 1'b1, 1'b0, 1'b0, DW'(i), DW'(i * 3), TW'(i), 1'b1, 1'b0);
      else        apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (i > 1) begin
        chk("stream out_valid", DW'(out_valid), 64'd1);
        chk("stream alu_result", alu_result, DW'(i - 1));
        chk("stream dest", DW'(dest), DW'(i - 1));
        chk("stream wb_en", DW'(wb_en), 64'd1);
      end
      tick();
    end

    // back-pressure table
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].iv, 1'b0, 1'b0, 1'b0, vecs[i].alu, '0, '0, vecs[i].ordy, 1'b0);
      chk("bp out_valid", DW'(out_valid), DW'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk("bp alu_result", alu_result, vecs[i].e_alu);
      chk("bp occupancy", DW'(occupancy), DW'(vecs[i].e_occ));
      chk("bp in_ready", DW'(in_ready), DW'(vecs[i].e_ir));
      tick();
    end

    // flush with occupancy 2 and a store offered at the same time
    apply(1'b1, 1'b0, 1'b0, 1'b0, 64'h10, '0, 5'd1, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 64'h11, '0, 5'd2, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD, '0, 5'd3, 1'b0, 1'b1);
    chk("flush pre occupancy", DW'(occupancy), 64'd2);
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("flush occupancy", DW'(occupancy), 64'd0);
    chk("flush mem_w_en", DW'(mem_w_en), 64'd0);
    tick();
    // flush while in_ready=1: the offered entry is discarded
    apply(1'b1, 1'b0, 1'b0, 1'b0, 64'h12, '0, 5'd4, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 1'b1, 64'hBEEF, '0, 5'd5, 1'b0, 1'b1);
    chk("flush2 in_ready", DW'(in_ready), 64'd1);
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("flush2 out_valid", DW'(out_valid), 64'd0);
    chk("flush2 occupancy", DW'(occupancy), 64'd0);
    tick();

    // gating: bubble between two loads
    apply(1'b1, 1'b0, 1'b1, 1'b0, 64'h21, '0, 5'd6, 1'b1, 1'b0); tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("gate first mem_r_en", DW'(mem_r_en), 64'd1);
    tick();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 64'h22, '0, 5'd7, 1'b1, 1'b0);
    chk("gate bubble out_valid", DW'(out_valid), 64'd0);
    chk("gate bubble mem_r_en", DW'(mem_r_en), 64'd0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("gate second alu_result", alu_result, 64'h22);
    chk("gate second mem_r_en", DW'(mem_r_en), 64'd1);
    tick();

    // wide data path, bit-exact
    apply(1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0001, 64'h8000_0000_0000_0000, 5'd31, 1'b1, 1'b0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("wide alu_result", alu_result, 64'hFFFF_FFFF_0000_0001);
    chk("wide val_rm", val_rm, 64'h8000_0000_0000_0000);
    chk("wide dest", DW'(dest), 64'd31);
    tick();

    // asynchronous reset mid-stream with occupancy 2
    apply(1'b1, 1'b1, 1'b0, 1'b0, 64'h31, '0, 5'd8, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 64'h32, '0, 5'd9, 1'b0, 1'b0); tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("prereset occupancy", DW'(occupancy), 64'd2);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async rst out_valid", DW'(out_valid), 64'd0);
    chk("async rst wb_en", DW'(wb_en), 64'd0);
    chk("async rst alu_result", alu_result, 64'd0);
    chk("async rst occupancy", DW'(occupancy), 64'd0);
    chk("async rst in_ready", DW'(in_ready), 64'd1);
    #1 rst = 1'b0;
    tick();

    // random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, TW'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
